// File: rtl/anubis_cbc_ctrl.sv
// anubis_cbc_ctrl: assembles 4x32-bit words into a block, optional CBC chaining, drives the Anubis core and serializes the result
module anubis_cbc_ctrl #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         iv_load,
  input  logic [127:0] iv_in,
  input  logic         mode_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         busy,
  output logic         timeout_err,
  output logic         core_start,
  output logic [127:0] core_plain_text,
  output logic [127:0] core_key,
  input  logic [127:0] core_cipher_text,
  input  logic         core_end_flag
);
  typedef enum logic [2:0] {COLLECT, START, WAIT_LOW, WAIT_HIGH, EMIT} state_t;
  state_t state_q, state_d;
  logic [1:0] word_cnt_q, word_cnt_d, out_cnt_q, out_cnt_d;
  logic [95:0] buf_q, buf_d;
  logic [127:0] plain_q, plain_d, key_q, key_d, chain_q, chain_d, cipher_q, cipher_d;
  logic mode_q, mode_d, terr_q, terr_d;
  logic [9:0] wd_q, wd_d;
  logic in_fire, out_fire, load_ok, waiting, done, expire, last_in;
  logic [127:0] block;
  always_comb begin
    in_fire  = state_q == COLLECT && in_valid;
    last_in  = in_fire && word_cnt_q == 2'd3;
    out_fire = state_q == EMIT && out_ready;
    load_ok  = state_q == COLLECT && word_cnt_q == 2'd0;
    waiting  = state_q == WAIT_LOW || state_q == WAIT_HIGH;
    done     = state_q == WAIT_HIGH && core_end_flag;
    // completion on the expiry cycle takes priority over the abort
    expire   = waiting && wd_q == 10'(TIMEOUT_CYCLES - 1) && !done;
    block    = {buf_q, in_data};
    buf_d      = in_fire ? {buf_q[63:0], in_data} : buf_q;
    word_cnt_d = in_fire ? word_cnt_q + 2'd1 : word_cnt_q;
    plain_d    = last_in ? (mode_q ? block ^ chain_q : block) : plain_q;
    key_d      = load_ok && key_load ? key_in : key_q;
    mode_d     = load_ok && iv_load ? mode_in : mode_q;
    chain_d    = load_ok && iv_load ? iv_in : done && mode_q ? core_cipher_text : chain_q;
    terr_d     = expire || (terr_q && !(load_ok && iv_load));
    cipher_d   = done ? core_cipher_text : cipher_q;
    out_cnt_d  = out_fire ? out_cnt_q + 2'd1 : out_cnt_q;
    wd_d       = state_q == START ? 10'd0 : waiting ? wd_q + 10'd1 : wd_q;
    state_d    = state_q;
    case (state_q)
      COLLECT:   state_d = last_in ? START : COLLECT;
      START:     state_d = WAIT_LOW;
      WAIT_LOW:  state_d = expire ? COLLECT : !core_end_flag ? WAIT_HIGH : WAIT_LOW;
      WAIT_HIGH: state_d = done ? EMIT : expire ? COLLECT : WAIT_HIGH;
      EMIT:      state_d = out_fire && out_cnt_q == 2'd3 ? COLLECT : EMIT;
      default:   state_d = COLLECT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= COLLECT;
      word_cnt_q <= '0;
      out_cnt_q  <= '0;
      buf_q      <= '0;
      plain_q    <= '0;
      key_q      <= '0;
      chain_q    <= '0;
      cipher_q   <= '0;
      mode_q     <= 1'b0;
      terr_q     <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      out_cnt_q  <= out_cnt_d;
      buf_q      <= buf_d;
      plain_q    <= plain_d;
      key_q      <= key_d;
      chain_q    <= chain_d;
      cipher_q   <= cipher_d;
      mode_q     <= mode_d;
      terr_q     <= terr_d;
      wd_q       <= wd_d;
    end
  end
  assign in_ready        = state_q == COLLECT;
  assign busy            = state_q != COLLECT;
  assign core_start      = state_q == START;
  assign out_valid       = state_q == EMIT;
  assign timeout_err     = terr_q;
  assign core_plain_text = plain_q;
  assign core_key        = key_q;
  assign out_data        = out_cnt_q == 2'd0 ? cipher_q[127:96] :
                           out_cnt_q == 2'd1 ? cipher_q[95:64] :
                           out_cnt_q == 2'd2 ? cipher_q[63:32] : cipher_q[31:0];
endmodule

// File: tb/tb_anubis_cbc_ctrl.sv
// tb_anubis_cbc_ctrl: scoreboard bench with an XOR core model plus a short-watchdog instance whose core never finishes
module tb_anubis_cbc_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, key_load = 1'b0, iv_load = 1'b0, mode_in = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic [127:0] key_in = '0, iv_in = '0;
  logic in_ready, out_valid, busy, timeout_err, core_start, core_end_flag;
  logic [31:0] out_data;
  logic [127:0] core_plain_text, core_key, core_cipher_text;
  logic s_in_ready, s_out_valid, s_busy, s_timeout_err, s_core_start;
  logic [31:0] s_out_data;
  logic [127:0] s_core_plain_text, s_core_key;
  int n_cmp = 0, n_bad = 0, lat = 0;
  logic sec_emit = 1'b0;
  logic [31:0] sb[$];
  logic [127:0] m_key = '0, m_chain = '0, exp_plain = '0;
  logic m_mode = 1'b0;
  always #5 clk = ~clk;
  anubis_cbc_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_load(key_load), .key_in(key_in), .iv_load(iv_load), .iv_in(iv_in), .mode_in(mode_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .timeout_err(timeout_err), .core_start(core_start), .core_plain_text(core_plain_text),
    .core_key(core_key), .core_cipher_text(core_cipher_text), .core_end_flag(core_end_flag)
  );
  anubis_cbc_ctrl #(.TIMEOUT_CYCLES(20)) dut_to (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .key_load(key_load), .key_in(key_in), .iv_load(iv_load), .iv_in(iv_in), .mode_in(mode_in),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .busy(s_busy),
    .timeout_err(s_timeout_err), .core_start(s_core_start), .core_plain_text(s_core_plain_text),
    .core_key(s_core_key), .core_cipher_text(128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0),
    .core_end_flag(1'b1)
  );
  always @(posedge clk) begin
    if (reset) begin
      core_end_flag <= 1'b1;
      core_cipher_text <= '0;
      lat <= 0;
    end else if (core_start) begin
      core_end_flag <= 1'b0;
      core_cipher_text <= core_plain_text ^ core_key;
      lat <= 60;
    end else if (!core_end_flag) begin
      if (lat == 1) core_end_flag <= 1'b1;
      lat <= lat - 1;
    end
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (s_out_valid) sec_emit = 1'b1;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_word", {96'd0, out_data}, 128'hX);
      else chk("out_word", {96'd0, out_data}, {96'd0, sb.pop_front()});
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_word(input logic [31:0] w);
    int t = 0;
    in_valid = 1'b1;
    in_data = w;
    while (!in_ready && t < 300) begin cyc(1); t++; end
    if (!in_ready) chk("in_ready_wait", {127'd0, in_ready}, 128'd1);
    cyc(1);
    in_valid = 1'b0;
  endtask
  task automatic send_block(input logic [127:0] b);
    for (int i = 0; i < 4; i++) send_word(b[127 - 32*i -: 32]);
  endtask
  task automatic expect_block(input logic [127:0] b);
    logic [127:0] c;
    exp_plain = m_mode ? b ^ m_chain : b;
    c = exp_plain ^ m_key;
    for (int i = 0; i < 4; i++) sb.push_back(c[127 - 32*i -: 32]);
    if (m_mode) m_chain = c;
  endtask
  task automatic load_cfg(input logic [127:0] k, input logic [127:0] iv, input logic m);
    key_load = 1'b1; key_in = k; iv_load = 1'b1; iv_in = iv; mode_in = m;
    cyc(1);
    key_load = 1'b0; iv_load = 1'b0;
    m_key = k; m_chain = iv; m_mode = m;
  endtask
  task automatic drain(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 600) begin cyc(1); t++; end
    chk({tag, "_drained"}, sb.size(), 0);
    cyc(1);
    chk({tag, "_back_to_collect"}, {127'd0, in_ready}, 128'd1);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
  initial begin
    logic [127:0] blk;
    int t;
    cyc(2);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_terr", {127'd0, timeout_err}, 128'd0);
    chk("rst_start", {127'd0, core_start}, 128'd0);
    chk("rst_out_data", {96'd0, out_data}, 128'd0);
    chk("rst_plain", core_plain_text, 128'd0);
    chk("rst_key", core_key, 128'd0);
    reset = 1'b0;
    cyc(1);
    // ECB block; the short-watchdog instance sees the same block and must abort it
    load_cfg({16{8'h0F}}, 128'd0, 1'b0);
    blk = 128'h11111111_22222222_33333333_44444444;
    expect_block(blk);
    send_block(blk);
    chk("ecb_start", {127'd0, core_start}, 128'd1);
    chk("ecb_plain", core_plain_text, exp_plain);
    chk("ecb_key", core_key, {16{8'h0F}});
    chk("ecb_stall", {127'd0, in_ready}, 128'd0);
    cyc(1);
    chk("ecb_start_once", {127'd0, core_start}, 128'd0);
    cyc(19);
    chk("to_not_yet", {127'd0, s_timeout_err}, 128'd0);
    chk("to_still_busy", {127'd0, s_busy}, 128'd1);
    cyc(1);
    chk("to_set", {127'd0, s_timeout_err}, 128'd1);
    chk("to_collect", {127'd0, s_busy}, 128'd0);
    chk("to_in_ready", {127'd0, s_in_ready}, 128'd1);
    drain("ecb");
    // CBC chaining with IV = 1
    load_cfg(128'd0, 128'd1, 1'b1);
    chk("to_cleared", {127'd0, s_timeout_err}, 128'd0);
    expect_block(128'd0);
    send_block(128'd0);
    chk("cbc1_plain", core_plain_text, exp_plain);
    chk("to_cbc1_plain", s_core_plain_text, 128'd1);
    drain("cbc1");
    expect_block(128'd0);
    send_block(128'd0);
    chk("cbc2_plain", core_plain_text, exp_plain);
    chk("to_chain_kept", s_core_plain_text, 128'd1);
    drain("cbc2");
    // iv_load mid-block is ignored
    blk = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    expect_block(blk);
    send_word(blk[127:96]);
    send_word(blk[95:64]);
    iv_load = 1'b1; iv_in = '1; mode_in = 1'b0;
    cyc(1);
    iv_load = 1'b0;
    send_word(blk[63:32]);
    send_word(blk[31:0]);
    chk("gate_plain", core_plain_text, exp_plain);
    drain("gate");
    // output backpressure: 5 stalled cycles per word
    out_ready = 1'b0;
    blk = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    expect_block(blk);
    send_block(blk);
    t = 0;
    while (!out_valid && t < 600) begin cyc(1); t++; end
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 5; k++) begin
        chk("bp_valid", {127'd0, out_valid}, 128'd1);
        chk("bp_data", {96'd0, out_data}, {96'd0, sb.size() != 0 ? sb[0] : 32'hX});
        chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
        cyc(1);
      end
      out_ready = 1'b1;
      cyc(1);
      out_ready = 1'b0;
    end
    chk("bp_all_out", sb.size(), 0);
    chk("bp_in_ready_after", {127'd0, in_ready}, 128'd1);
    out_ready = 1'b1;
    // reset in the middle of EMIT
    blk = 128'hCAFEBABE_00000001_80000000_FFFF0000;
    expect_block(blk);
    send_block(blk);
    t = 0;
    while (sb.size() != 2 && t < 600) begin cyc(1); t++; end
    chk("mid_emit_reached", sb.size(), 2);
    out_ready = 1'b0;
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("mid_rst_plain", core_plain_text, 128'd0);
    chk("mid_rst_key", core_key, 128'd0);
    reset = 1'b0;
    sb.delete();
    m_key = '0; m_chain = '0; m_mode = 1'b0;
    out_ready = 1'b1;
    cyc(1);
    blk = 128'h0BADF00D_13579BDF_2468ACE0_DEADC0DE;
    expect_block(blk);
    send_block(blk);
    chk("post_rst_plain", core_plain_text, blk);
    drain("post_rst");
    chk("to_no_output", {127'd0, sec_emit}, 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
